// File: rtl/pattern_pkg.sv
// ----------------------------------------------------------------------------
// pattern_pkg
// Shared defaults and FSM state type for the pattern inserter and window
// matcher.
//   PAT_CW   : default carrier width in bits
//   PAT_PW   : default pattern width in bits (PAT_PW <= PAT_CW)
//   PAT_NPOS : number of window positions for the defaults
//   state_e  : inserter FSM states
// ----------------------------------------------------------------------------
package pattern_pkg;

    localparam int unsigned PAT_CW   = 8;
    localparam int unsigned PAT_PW   = 4;
    localparam int unsigned PAT_NPOS = PAT_CW - PAT_PW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INSERT = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Width of an index able to address NPOS window positions.
    function automatic int unsigned idx_width(input int unsigned npos);
        return (npos > 1) ? $clog2(npos) : 1;
    endfunction

endpackage

// File: rtl/pattern_window_match.sv
// ----------------------------------------------------------------------------
// pattern_window_match
// Combinational sliding-window compare: flags every position k where the
// carrier slice [k+PW-1:k] equals the pattern.
//   i_word  [CW-1:0]      : carrier word
//   i_pat   [PW-1:0]      : pattern
//   o_match [CW-PW:0]     : bit k set iff i_word[k+PW-1:k] == i_pat
// ----------------------------------------------------------------------------
module pattern_window_match
    import pattern_pkg::*;
#(
    parameter int unsigned CW = PAT_CW,
    parameter int unsigned PW = PAT_PW
) (
    input  logic [CW-1:0]    i_word,
    input  logic [PW-1:0]    i_pat,
    output logic [CW-PW:0]   o_match
);

    localparam int unsigned NPOS = CW - PW + 1;

    always_comb begin
        o_match = '0;
        for (int k = 0; k < NPOS; k++) begin
            o_match[k] = (i_word[k +: PW] == i_pat);
        end
    end

endmodule

// File: rtl/pattern_inserter.sv
// ----------------------------------------------------------------------------
// pattern_inserter
// Builds a carrier word with a pattern written at each requested window
// position (highest position first, one position per cycle), then checks the
// finished word with pattern_window_match and presents word, flags and status.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : request present
//   in_ready   : request can be accepted (IDLE only)
//   c_in       : carrier word
//   d_in       : pattern
//   pos_mask   : bit k requests insertion at position k
//   out_valid  : result present
//   out_ready  : consumer takes the result
//   word_out   : carrier after insertion
//   match_out  : per-position match flags on word_out
//   ok_out     : every requested position still holds the pattern
// ----------------------------------------------------------------------------
module pattern_inserter
    import pattern_pkg::*;
#(
    parameter int unsigned CW = PAT_CW,
    parameter int unsigned PW = PAT_PW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW-1:0]   c_in,
    input  logic [PW-1:0]   d_in,
    input  logic [CW-PW:0]  pos_mask,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   word_out,
    output logic [CW-PW:0]  match_out,
    output logic            ok_out
);

    localparam int unsigned NPOS = CW - PW + 1;
    localparam int unsigned IW   = idx_width(NPOS);

    state_e              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [CW-1:0]       r_word;
    logic [PW-1:0]       r_pat;
    logic [NPOS-1:0]     r_mask;
    logic [IW-1:0]       r_idx;
    logic [CW-1:0]       r_word_out;
    logic [NPOS-1:0]     r_match_out;
    logic                r_ok_out;

    logic [CW-1:0]       w_word_ins;
    logic [NPOS-1:0]     w_match;

    // Word after this cycle's candidate position (r_idx) is written, if masked.
    always_comb begin
        w_word_ins = r_word;
        for (int k = 0; k < NPOS; k++) begin
            if ((r_idx == IW'(k)) && r_mask[k]) begin
                w_word_ins[k +: PW] = r_pat;
            end
        end
    end

    pattern_window_match #(
        .CW (CW),
        .PW (PW)
    ) u_match (
        .i_word  (r_word),
        .i_pat   (r_pat),
        .o_match (w_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_word      <= '0;
            r_pat       <= '0;
            r_mask      <= '0;
            r_idx       <= '0;
            r_word_out  <= '0;
            r_match_out <= '0;
            r_ok_out    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_word     <= c_in;
                        r_pat      <= d_in;
                        r_mask     <= pos_mask;
                        r_idx      <= IW'(NPOS - 1);
                        r_in_ready <= 1'b0;
                        r_state    <= INSERT;
                    end else begin
                        // Re-arms one cycle after returning from DONE.
                        r_in_ready <= 1'b1;
                    end
                end
                INSERT: begin
                    r_word <= w_word_ins;
                    if (r_idx == '0) begin
                        r_state <= VERIFY;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                VERIFY: begin
                    r_word_out  <= r_word;
                    r_match_out <= w_match;
                    r_ok_out    <= ((w_match & r_mask) == r_mask);
                    r_state     <= DONE;
                end
                DONE: begin
                    // Results are already stable; out_valid is raised on the
                    // first DONE edge and held until the consumer takes them.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign word_out  = r_word_out;
    assign match_out = r_match_out;
    assign ok_out    = r_ok_out;

endmodule

// File: tb/tb_pattern_inserter.sv
module tb_pattern_inserter;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] c_in;
    logic [3:0] d_in;
    logic [4:0] pos_mask;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] word_out;
    logic [4:0] match_out;
    logic       ok_out;

    int checks;
    int errors;

    pattern_inserter #(
        .CW (8),
        .PW (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_in      (c_in),
        .d_in      (d_in),
        .pos_mask  (pos_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_out  (word_out),
        .match_out (match_out),
        .ok_out    (ok_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c;
        logic [3:0] d;
        logic [4:0] m;
        logic [7:0] w;
        logic [4:0] mt;
        logic       ok;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one request for one accept edge,
    // then scrambles the inputs so a late-sampling DUT would be caught.
    task automatic send(input logic [7:0] c, input logic [3:0] d, input logic [4:0] m);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        c_in     = c;
        d_in     = d;
        pos_mask = m;
        tick();
        in_valid = 1'b0;
        c_in     = ~c;
        d_in     = ~d;
        pos_mask = ~m;
        chk("in_ready_busy", 32'(in_ready), 32'd0);
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_word"}, 32'(word_out), 32'(v.w));
        chk({tag, "_match"}, 32'(match_out), 32'(v.mt));
        chk({tag, "_ok"}, 32'(ok_out), 32'(v.ok));
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    endtask

    // Handshake: out_valid drops at the taking edge, in_ready rises one edge later.
    task automatic take_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_gap"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [7:0] held_w;
        logic [4:0] held_m;
        logic       held_ok;

        checks = 0;
        errors = 0;

        //          carrier      pattern   mask      word         match     ok
        vecs[0] = '{8'b00000000, 4'b1110, 5'b10000, 8'b11100000, 5'b10000, 1'b1};
        vecs[1] = '{8'b00000000, 4'b1010, 5'b00101, 8'b00101010, 5'b00101, 1'b1};
        vecs[2] = '{8'b00000000, 4'b1100, 5'b00011, 8'b00011100, 5'b00001, 1'b0};
        vecs[3] = '{8'b11101011, 4'b1010, 5'b00000, 8'b11101011, 5'b00100, 1'b1};
        vecs[4] = '{8'b11111111, 4'b0000, 5'b11111, 8'b00000000, 5'b11111, 1'b1};
        vecs[5] = '{8'b01011010, 4'b1111, 5'b01000, 8'b01111010, 5'b01000, 1'b1};
        vecs[6] = '{8'b00000000, 4'b1001, 5'b10001, 8'b10011001, 5'b10001, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        c_in      = '0;
        d_in      = '0;
        pos_mask  = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_word", 32'(word_out), 32'd0);
        chk("reset_match", 32'(match_out), 32'd0);
        chk("reset_ok", 32'(ok_out), 32'd0);

        // out_valid is expected on the 7th edge after the accept edge.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].c, vecs[i].d, vecs[i].m);
            wait_result(lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd7);
            check_result($sformatf("vec%0d", i), vecs[i]);
            take_result($sformatf("vec%0d", i));
        end

        // Backpressure on the mask=0 case: results hold, busy pulses ignored.
        send(vecs[3].c, vecs[3].d, vecs[3].m);
        wait_result(lat);
        chk("bp_latency", 32'(lat), 32'd7);
        check_result("bp", vecs[3]);
        held_w  = word_out;
        held_m  = match_out;
        held_ok = ok_out;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            c_in     = 8'hA5 ^ 8'(i);
            d_in     = 4'(i);
            pos_mask = 5'b11111;
            tick();
            chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_word_hold", 32'(word_out), 32'(held_w));
            chk("bp_match_hold", 32'(match_out), 32'(held_m));
            chk("bp_ok_hold", 32'(ok_out), 32'(held_ok));
        end
        in_valid = 1'b0;
        take_result("bp");

        // Reset during the 3rd INSERT cycle aborts the request.
        send(vecs[0].c, vecs[0].d, vecs[0].m);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_word", 32'(word_out), 32'd0);
        chk("midrst_match", 32'(match_out), 32'd0);
        chk("midrst_ok", 32'(ok_out), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);

        // The aborted request must not surface; a new one completes normally.
        send(vecs[1].c, vecs[1].d, vecs[1].m);
        wait_result(lat);
        chk("post_rst_latency", 32'(lat), 32'd7);
        check_result("post_rst", vecs[1]);
        take_result("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
